// File: rtl/multicycle_ctrl.sv
// Main control unit for the multicycle MIPS core.
// A Moore FSM sequences fetch/decode/execute/memory/writeback. It decodes
// op/funct into datapath selects and write enables, and it counts retired
// instructions.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,      // asynchronous, active-low
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pcen,
  output logic             irwrite,
  output logic             memwrite,
  output logic             regwrite,
  output logic             iord,
  output logic             memtoreg,
  output logic             regdst,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [2:0]       alucontrol,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic       pcwrite_s, branch_s, irwrite_s, memwrite_s, regwrite_s;
  logic [1:0] aluop_s;
  logic       retire_s;
  logic       op_legal_s;

  // Ops that DECODE knows how to dispatch; anything else is illegal.
  always_comb begin
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal_s = 1'b1;
      default:                                       op_legal_s = 1'b0;
    endcase
  end

  // State register; reset parks the FSM in FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; op is only looked at in DECODE and MEMADR.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        // An op that is neither lw nor sw here means a corrupted IR; drop it.
        if (op == OP_LW) begin
          state_d = MEMRD;
        end else if (op == OP_SW) begin
          state_d = MEMWR;
        end else begin
          state_d = FETCH;
        end
      end
      MEMRD:   state_d = MEMWB;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP: state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Moore output decode; every control defaults to 0.
  always_comb begin
    pcwrite_s  = 1'b0;
    branch_s   = 1'b0;
    irwrite_s  = 1'b0;
    memwrite_s = 1'b0;
    regwrite_s = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop_s    = 2'b00;
    retire_s   = 1'b0;
    case (state_q)
      FETCH: begin
        irwrite_s = 1'b1;
        pcwrite_s = 1'b1;
        alusrcb   = 2'b01;
      end
      DECODE:  alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:   iord = 1'b1;
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
        retire_s   = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
        retire_s   = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop_s = 2'b10;
      end
      ALUWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
        retire_s   = 1'b1;
      end
      BRANCH: begin
        alusrca  = 1'b1;
        aluop_s  = 2'b01;
        pcsrc    = 2'b01;
        branch_s = 1'b1;
        retire_s = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB: begin
        regwrite_s = 1'b1;
        retire_s   = 1'b1;
      end
      JUMP: begin
        pcsrc     = 2'b10;
        pcwrite_s = 1'b1;
        retire_s  = 1'b1;
      end
      default: begin
        alusrcb = 2'b01;
      end
    endcase
  end

  // ALU decode from aluop, with funct selecting the R-type operation.
  always_comb begin
    alucontrol = 3'b010;
    case (aluop_s)
      2'b00: alucontrol = 3'b010;
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

  // Retired counter advances when a final step hands back to FETCH.
  always_comb begin
    if (retire_s) begin
      retired_d = retired_q + CNT_W'(1);
    end else begin
      retired_d = retired_q;
    end
  end

  // Retired counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  // Write enables are held off while reset is low, even though FETCH
  // would otherwise drive irwrite/pcwrite.
  assign pcen     = reset & (pcwrite_s | (branch_s & zero));
  assign irwrite  = reset & irwrite_s;
  assign memwrite = reset & memwrite_s;
  assign regwrite = reset & regwrite_s;
  assign illegal  = (state_q == DECODE) & ~op_legal_s;
  assign state    = state_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver pushes hand-computed
// per-cycle expectations, and a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

  logic        clk;
  logic        reset;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic        pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0]  alusrcb, pcsrc;
  logic [2:0]  alucontrol;
  logic [3:0]  state;
  logic        illegal;
  logic [31:0] retired;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state),
    .illegal(illegal), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          cyc;
    logic [19:0] vec;
    logic [31:0] ret;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_ret;

  // Expected control vector for one state, straight from the output table.
  function automatic logic [19:0] exp_vec(input logic [3:0] st, input logic [2:0] ex_alu,
                                          input logic z, input logic ill);
    logic       e_pcen, e_irw, e_mw, e_rw, e_iord, e_mtr, e_rd, e_asa, e_ill;
    logic [1:0] e_asb, e_psrc;
    logic [2:0] e_alu;
    e_pcen = 1'b0; e_irw = 1'b0; e_mw = 1'b0; e_rw = 1'b0; e_iord = 1'b0;
    e_mtr = 1'b0; e_rd = 1'b0; e_asa = 1'b0; e_asb = 2'b00; e_psrc = 2'b00;
    e_alu = 3'b010; e_ill = 1'b0;
    case (st)
      4'd0:  begin e_irw = 1'b1; e_pcen = 1'b1; e_asb = 2'b01; end
      4'd1:  begin e_asb = 2'b11; e_ill = ill; end
      4'd2:  begin e_asa = 1'b1; e_asb = 2'b10; end
      4'd3:  begin e_iord = 1'b1; end
      4'd4:  begin e_mtr = 1'b1; e_rw = 1'b1; end
      4'd5:  begin e_iord = 1'b1; e_mw = 1'b1; end
      4'd6:  begin e_asa = 1'b1; e_alu = ex_alu; end
      4'd7:  begin e_rd = 1'b1; e_rw = 1'b1; end
      4'd8:  begin e_asa = 1'b1; e_alu = 3'b110; e_psrc = 2'b01; e_pcen = z; end
      4'd9:  begin e_asa = 1'b1; e_asb = 2'b10; end
      4'd10: begin e_rw = 1'b1; end
      4'd11: begin e_psrc = 2'b10; e_pcen = 1'b1; end
      default: begin end
    endcase
    return {st, e_pcen, e_irw, e_mw, e_rw, e_iord, e_mtr, e_rd, e_asa,
            e_asb, e_psrc, e_alu, e_ill};
  endfunction

  // Monitor: compare the DUT outputs against the oldest pending expectation.
  always @(negedge clk) begin
    exp_t        e;
    logic [19:0] act;
    if (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      act = {state, pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
             alusrca, alusrcb, pcsrc, alucontrol, illegal};
      total++;
      if (act !== e.vec) begin
        bad++;
        $display("FAIL %s cyc%0d ctrl: got %05h want %05h", e.tag, e.cyc, act, e.vec);
      end
      total++;
      if (retired !== e.ret) begin
        bad++;
        $display("FAIL %s cyc%0d retired: got %0d want %0d", e.tag, e.cyc, retired, e.ret);
      end
    end
  end

  // Direct comparison used outside the scoreboard (reset and abort checks).
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Drive one instruction; seq holds the expected states, first in [3:0].
  task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int n, input logic [23:0] seq,
                           input logic [2:0] ex_alu, input logic ill, input logic ret);
    exp_t e;
    op = o; funct = f; zero = z;
    for (int i = 0; i < n; i++) begin
      e.tag = name;
      e.cyc = i;
      e.vec = exp_vec(seq[4*i +: 4], ex_alu, z, ill);
      e.ret = exp_ret;
      sb_q.push_back(e);
      @(posedge clk); #1;
    end
    if (ret) exp_ret = exp_ret + 32'd1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0;
    exp_ret = 32'd0;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state",    {28'd0, state},      32'd0);
    chk("rst_retired",  retired,             32'd0);
    chk("rst_we",       {28'd0, pcen, irwrite, memwrite, regwrite}, 32'd0);
    chk("rst_alusrcb",  {30'd0, alusrcb},    32'd1);
    chk("rst_alu",      {29'd0, alucontrol}, 32'd2);
    chk("rst_illegal",  {31'd0, illegal},    32'd0);
    reset = 1'b1;

    run_instr("addi", 6'b001000, 6'd0, 1'b0, 4, {8'd0, 4'd10, 4'd9, 4'd1, 4'd0}, 3'b010, 1'b0, 1'b1);
    run_instr("lw",   6'b100011, 6'd0, 1'b0, 5, {4'd0, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 3'b010, 1'b0, 1'b1);
    run_instr("sw",   6'b101011, 6'd0, 1'b0, 4, {8'd0, 4'd5, 4'd2, 4'd1, 4'd0}, 3'b010, 1'b0, 1'b1);
    run_instr("sub",  6'b000000, 6'b100010, 1'b0, 4, {8'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 3'b110, 1'b0, 1'b1);
    run_instr("slt",  6'b000000, 6'b101010, 1'b0, 4, {8'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 3'b111, 1'b0, 1'b1);
    run_instr("or",   6'b000000, 6'b100101, 1'b0, 4, {8'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 3'b001, 1'b0, 1'b1);
    run_instr("and",  6'b000000, 6'b100100, 1'b0, 4, {8'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 3'b000, 1'b0, 1'b1);
    run_instr("add",  6'b000000, 6'b100000, 1'b0, 4, {8'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 3'b010, 1'b0, 1'b1);
    run_instr("rbad", 6'b000000, 6'b111111, 1'b0, 4, {8'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 3'b010, 1'b0, 1'b1);
    run_instr("beqT", 6'b000100, 6'd0, 1'b1, 3, {12'd0, 4'd8, 4'd1, 4'd0}, 3'b010, 1'b0, 1'b1);
    run_instr("beqN", 6'b000100, 6'd0, 1'b0, 3, {12'd0, 4'd8, 4'd1, 4'd0}, 3'b010, 1'b0, 1'b1);
    run_instr("j",    6'b000010, 6'd0, 1'b0, 3, {12'd0, 4'd11, 4'd1, 4'd0}, 3'b010, 1'b0, 1'b1);
    run_instr("ill",  6'b111111, 6'd0, 1'b0, 2, {16'd0, 4'd1, 4'd0}, 3'b010, 1'b1, 1'b0);
    chk("ill_next_state", {28'd0, state}, 32'd0);
    chk("ill_retired",    retired,        exp_ret);

    // Abort a lw in MEMRD with an asynchronous reset pulse.
    run_instr("abort", 6'b100011, 6'd0, 1'b0, 3, {12'd0, 4'd2, 4'd1, 4'd0}, 3'b010, 1'b0, 1'b0);
    chk("abort_pre_state", {28'd0, state}, 32'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_state",    {28'd0, state}, 32'd0);
    chk("abort_retired",  retired,        32'd0);
    chk("abort_regwrite", {31'd0, regwrite}, 32'd0);
    @(posedge clk); #1;
    chk("abort_hold_state", {28'd0, state}, 32'd0);
    chk("abort_hold_we",    {28'd0, pcen, irwrite, memwrite, regwrite}, 32'd0);
    exp_ret = 32'd0;
    reset = 1'b1;

    run_instr("addi2", 6'b001000, 6'd0, 1'b0, 4, {8'd0, 4'd10, 4'd9, 4'd1, 4'd0}, 3'b010, 1'b0, 1'b1);
    sb_q.push_back('{tag: "post", cyc: 0, vec: exp_vec(4'd0, 3'b010, 1'b0, 1'b0), ret: exp_ret});

    repeat (2) @(negedge clk);
    #1;
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control unit for the multicycle MIPS core. A Moore FSM sequences the shared ALU, memory port, IR and register file across the fetch, decode, execute, memory and writeback steps. It decodes op/funct into datapath selects and write enables. It also keeps a retired-instruction counter that benches use to check progress alongside pc.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
op  in  6  instr[31:26] from IR
funct  in  6  instr[5:0] from IR
zero  in  1  ALU zero flag
pcen  out  1  PC write enable = pcwrite | (branch & zero)
irwrite  out  1  IR load
memwrite  out  1  data memory write
regwrite  out  1  register file write
iord  out  1  memory address select: 0=pc, 1=aluout
memtoreg  out  1  writeback select: 1=mem data
regdst  out  1  dest select: 1=rd, 0=rt
alusrca  out  1  ALU A select: 0=pc, 1=rs
alusrcb  out  2  ALU B select: 00=rt, 01=4, 10=signimm, 11=signimm<<2
pcsrc  out  2  next-PC select: 00=aluresult, 01=aluout, 10=jump target
alucontrol  out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt
state  out  4  current state encoding (debug)
illegal  out  1  high during DECODE when op is unsupported
retired  out  CNT_W  count of completed instructions

Behaviour:
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12-15 are unreachable; if entered, next state is FETCH.
- Transitions:
  - FETCH->DECODE.
  - DECODE by op: 100011 (lw) or 101011 (sw) -> MEMADR; 000000 (R-type) -> EXECUTE; 000100 (beq) -> BRANCH; 001000 (addi) -> ADDIEX; 000010 (j) -> JUMP; any other op -> FETCH with illegal=1.
  - MEMADR: lw -> MEMRD, sw -> MEMWR.
  - MEMRD->MEMWB. EXECUTE->ALUWB. ADDIEX->ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP -> FETCH.
- Latency, FETCH to FETCH: lw 5 cycles; sw, R-type and addi 4; beq and j 3; illegal 2.
- Outputs are Moore, decoded from state; alucontrol in EXECUTE also depends on funct combinationally. Every signal not listed for a state is 0.
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00.
  - DECODE: alusrcb=11, aluop=00.
  - MEMADR: alusrca=1, alusrcb=10.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - EXECUTE: alusrca=1, alusrcb=00, aluop=10.
  - ALUWB: regdst=1, regwrite=1.
  - BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - ADDIEX: alusrca=1, alusrcb=10.
  - ADDIWB: regwrite=1.
  - JUMP: pcsrc=10, pcwrite=1.
- ALU decode:
  - aluop 00 -> 010; aluop 01 -> 110.
  - aluop 10 by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other funct -> 010.
- retired:
  - +1 on every clock edge that moves from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP to FETCH.
  - Not incremented on the illegal DECODE->FETCH path.
  - Wraps to 0 after all-ones.
- Reset (reset=0), asynchronous:
  - state=FETCH immediately, retired=0, illegal=0.
  - pcen, irwrite, memwrite and regwrite are forced to 0 for as long as reset is low.
  - Other outputs take their FETCH values: alusrcb=01, alucontrol=010, the rest 0.
  - First FETCH executes on the first rising edge after reset rises.
  - Reset asserted mid-instruction aborts it; no further write enables and no retired increment.
- beq: pcen=zero in BRANCH. The instruction retires whether or not the branch is taken.
- op/funct are sampled only in DECODE, MEMADR and EXECUTE. IR is stable there because irwrite=1 only in FETCH.

Test Plan:
- Reset: hold reset=0 for 3 cycles -> state=0, retired=0, pcen=irwrite=memwrite=regwrite=0, alusrcb=01. Release -> next edge state=1.
- addi (op=001000): state sequence 0,1,9,10,0. regwrite=1 only in state 10, regdst=0, memtoreg=0. retired=1 after 4 cycles.
- lw then sw: lw takes 5 cycles, memtoreg=1 and regwrite=1 in state 4. sw takes 4 cycles, memwrite=1 and iord=1 in state 5 only. retired=2.
- R-type: funct 100010 gives alucontrol=110 in state 6. Repeat with 101010 -> 111, 100101 -> 001, 111111 -> 010. regdst=1 in state 7.
- beq: zero=1 -> pcen=1, pcsrc=01 in state 8. zero=0 -> pcen=0. Both take 3 cycles and increment retired.
- j, illegal and abort:
  - j: pcen=1, pcsrc=10 in state 11.
  - op=111111: illegal=1 in state 1, then state 0; retired unchanged.
  - reset pulsed low during state 3: state=0 asynchronously, retired=0, regwrite never asserted.
